// File: rtl/cond_logic.sv
// Conditional-execution unit: flag register, condition check and write gating.
// Optional COND_PERF_EN adds saturating executed/skipped instruction counters.
module cond_logic #(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       InstrEnd,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondExDelayed
`ifdef COND_PERF_EN
  ,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SkipCnt
`endif
);

  logic       condEx;
  logic [1:0] flagWrite;
  logic       n, z, c, v;

  assign {n, z, c, v} = Flags;

  always_comb begin
    condEx = 1'b1;
    unique case (Cond)
      4'h0: condEx = z;
      4'h1: condEx = !z;
      4'h2: condEx = c;
      4'h3: condEx = !c;
      4'h4: condEx = n;
      4'h5: condEx = !n;
      4'h6: condEx = v;
      4'h7: condEx = !v;
      4'h8: condEx = c & !z;
      4'h9: condEx = !c | z;
      4'hA: condEx = (n == v);
      4'hB: condEx = (n != v);
      4'hC: condEx = !z & (n == v);
      4'hD: condEx = z | (n != v);
      default: condEx = 1'b1;
    endcase
  end

  assign flagWrite = FlagW & {condEx, condEx};

  always_ff @(posedge clk) begin
    if (reset) begin
      Flags         <= 4'b0000;
      CondExDelayed <= 1'b0;
    end else begin
      if (flagWrite[1]) Flags[3:2] <= ALUFlags[3:2];
      if (flagWrite[0]) Flags[1:0] <= ALUFlags[1:0];
      CondExDelayed <= condEx;
    end
  end

  // Reset masks a stale CondExDelayed left over from before reset.
  assign RegWrite = RegW & CondExDelayed & !reset;
  assign MemWrite = MemW & CondExDelayed & !reset;
  assign PCWrite  = (PCS & CondExDelayed & !reset) | NextPC;

`ifdef COND_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ExecCnt <= '0;
      SkipCnt <= '0;
    end else if (InstrEnd) begin
      if (CondExDelayed) begin
        if (ExecCnt != '1) ExecCnt <= ExecCnt + CNT_W'(1);
      end else begin
        if (SkipCnt != '1) SkipCnt <= SkipCnt + CNT_W'(1);
      end
    end
  end
`else
  logic unusedInstrEnd;
  localparam int unusedCntW = CNT_W;
  assign unusedInstrEnd = InstrEnd;
`endif

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of each statistics counter.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Cond, input, 4 bits: condition field Instr[31:28].
REQ-005 The block SHALL have port ALUFlags, input, 4 bits: {N,Z,C,V} from the datapath ALU.
REQ-006 The block SHALL have port FlagW, input, 2 bits, from the decoder: bit1 requests an NZ write, bit0 requests a CV write.
REQ-007 The block SHALL have inputs PCS, NextPC, RegW and MemW, 1 bit each: raw decoder/FSM write requests.
REQ-008 The block SHALL have port InstrEnd, input, 1 bit: one-cycle pulse in an instruction's final FSM state.
REQ-009 The block SHALL have outputs PCWrite, RegWrite and MemWrite, 1 bit each: gated write enables to the datapath.
REQ-010 The block SHALL have port Flags, output, 4 bits: registered {N,Z,C,V}.
REQ-011 The block SHALL have port CondExDelayed, output, 1 bit: registered condition-pass result.

Function
REQ-012 CondEx SHALL be combinational from Cond and Flags: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E and F 1.
REQ-013 CondExDelayed SHALL load CondEx on every clock edge (1-cycle latency).
REQ-014 FlagWrite[1:0] SHALL equal FlagW & {CondEx,CondEx}; each Flags pair SHALL update independently on the next edge (FlagWrite[1]: Flags[3:2] <= ALUFlags[3:2]; FlagWrite[0]: Flags[1:0] <= ALUFlags[1:0]).
REQ-015 Flags SHALL hold whenever its corresponding FlagWrite bit is 0.
REQ-016 RegWrite SHALL equal RegW & CondExDelayed, and MemWrite SHALL equal MemW & CondExDelayed, combinationally.
REQ-017 PCWrite SHALL equal (PCS & CondExDelayed) | NextPC; NextPC (fetch) SHALL never be gated.
REQ-018 When a flag write and a condition evaluation fall in the same cycle, CondEx SHALL use the pre-write Flags; the new flags SHALL be visible from the next cycle.
REQ-019 A condition-failed instruction SHALL assert no RegWrite, MemWrite or PCS-driven PCWrite and SHALL leave Flags unchanged.

Reset
REQ-020 On reset, Flags SHALL be 4'b0000 and CondExDelayed SHALL be 0 on the next edge.
REQ-021 During reset, RegWrite and MemWrite SHALL be 0, PCWrite SHALL equal NextPC, and counters SHALL be 0 when COND_PERF_EN is defined.
REQ-022 A reset asserted mid-instruction SHALL take priority over any simultaneous flag write or counter increment.

Configuration
REQ-023 When macro COND_PERF_EN is defined, the block SHALL add outputs ExecCnt and SkipCnt, each CNT_W bits.
REQ-024 With COND_PERF_EN, on an edge with InstrEnd=1 the block SHALL increment ExecCnt if CondExDelayed=1, else SkipCnt.
REQ-025 With COND_PERF_EN, each counter SHALL saturate at all-ones without wrapping.
REQ-026 When COND_PERF_EN is not defined, ExecCnt and SkipCnt SHALL be absent, InstrEnd SHALL be ignored, and all other behaviour SHALL be identical.

Verification
REQ-027 Reset scenario: reset high for 2 cycles, then low -> Flags=0000, CondExDelayed=0; Cond=E next cycle -> CondExDelayed=1 one cycle later.
REQ-028 Flag write scenario: Cond=E, FlagW=11, ALUFlags=0100 (SUB equal) -> Flags=0100; then Cond=0 (EQ), PCS=1 -> PCWrite=1 one cycle later; Cond=1 (NE) -> PCWrite=0.
REQ-029 Partial flag write scenario: with Flags=0100, FlagW=10, ALUFlags=1011 -> Flags=1000 (CV retained as 00).
REQ-030 Failed-condition scenario: Flags=0000, Cond=0, RegW=1, MemW=1, FlagW=11, ALUFlags=1111 -> RegWrite=0, MemWrite=0, Flags stays 0000.
REQ-031 Signed-condition scenario: Flags=1001 (N=V) -> GE=1, LT=0, GT=1, LE=0; Flags=1101 -> GT=0, LE=1.
REQ-032 Counter scenario (COND_PERF_EN, CNT_W=2): 5 InstrEnd pulses with CondExDelayed=1 -> ExecCnt=3 (saturated), SkipCnt=0; 1 pulse with CondExDelayed=0 -> SkipCnt=1.
